// File: rtl/axi2s_mreg_pkg.sv
// axi2s_mreg_pkg: register offsets, bit indices, reset values and adjust FSM type
package axi2s_mreg_pkg;
   localparam logic [5:0] OFF_CTRL      = 6'h00;
   localparam logic [5:0] OFF_STICKY    = 6'h04;
   localparam logic [5:0] OFF_MASK      = 6'h08;
   localparam logic [5:0] OFF_IBASE     = 6'h10;
   localparam logic [5:0] OFF_ISIZE     = 6'h14;
   localparam logic [5:0] OFF_OBASE     = 6'h18;
   localparam logic [5:0] OFF_OSIZE     = 6'h1C;
   localparam logic [5:0] OFF_FRAME_LEN = 6'h20;
   localparam logic [5:0] OFF_FRAME_ADJ = 6'h24;
   localparam logic [5:0] OFF_TSTART    = 6'h30;
   localparam logic [5:0] OFF_TEND      = 6'h34;
   localparam logic [5:0] OFF_RSTART    = 6'h38;
   localparam logic [5:0] OFF_REND      = 6'h3C;
   localparam logic [5:0] OFF_STATE     = OFF_CTRL;
   localparam logic [5:0] OFF_IACNT     = OFF_IBASE;
   localparam logic [5:0] OFF_IBCNT     = OFF_ISIZE;
   localparam logic [5:0] OFF_OACNT     = OFF_OBASE;
   localparam logic [5:0] OFF_OBCNT     = OFF_OSIZE;
   localparam int ST_IEN     = 0;
   localparam int ST_OEN     = 1;
   localparam int ST_TDD     = 2;
   localparam int ST_ADJ     = 3;
   localparam int ST_COMMIT  = 4;
   localparam int SK_IERR    = 0;
   localparam int SK_OERR    = 1;
   localparam int SK_ADJ_OVR = 2;
   localparam int SK_COMMIT  = 3;
   localparam logic [31:0] RST_IBASE     = 32'hFFFC_0000;
   localparam logic [31:0] RST_OBASE     = 32'hFFFD_0000;
   localparam logic [17:0] RST_SIZE      = 18'h400;
   localparam logic [23:0] RST_FRAME_LEN = 24'd1920;
   localparam logic [23:0] RST_END       = 24'd1919;
   typedef enum logic {ADJ_IDLE, ADJ_PEND} adj_st_t;
endpackage

// File: rtl/axi2s_mreg_chan.sv
// axi2s_mreg_chan: one channel's registers, adjust FSM, sticky/irq and (AXI2S_MREG_SHADOW_EN) timing shadows
module axi2s_mreg_chan
   import axi2s_mreg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [5:0]  off,
   input  logic [31:0] din,
   output logic [31:0] rdata,
   output logic        ien,
   output logic        oen,
   output logic        tddmode,
   output logic        test,
   output logic [31:0] ibase,
   output logic [31:0] obase,
   output logic [17:0] isize,
   output logic [17:0] osize,
   output logic [23:0] frame_len,
   output logic [23:0] tstart,
   output logic [23:0] tend,
   output logic [23:0] rstart,
   output logic [23:0] rend,
   output logic [23:0] frame_adj,
   output logic        adj_pending,
   input  logic        adj_ack,
   input  logic        frame_strobe,
   input  logic [17:0] iacnt,
   input  logic [17:0] oacnt,
   input  logic [31:0] ibcnt,
   input  logic [31:0] obcnt,
   input  logic        ierr,
   input  logic        oerr,
   output logic        irq
);
   logic [3:0] ctrl, sticky, mask, sk_clr;
   logic       wr_len, wr_ts, wr_te, wr_rs, wr_re, wr_adj, adj_ovr;
   logic       commit_pend, commit_done;
   adj_st_t    adj_st, adj_nx;

   assign {test, tddmode, oen, ien} = ctrl;
   assign wr_len = we && off == OFF_FRAME_LEN;
   assign wr_ts  = we && off == OFF_TSTART;
   assign wr_te  = we && off == OFF_TEND;
   assign wr_rs  = we && off == OFF_RSTART;
   assign wr_re  = we && off == OFF_REND;
   assign wr_adj = we && off == OFF_FRAME_ADJ;
   assign sk_clr = (we && off == OFF_STICKY) ? din[3:0] : 4'h0;
   assign adj_pending = adj_st == ADJ_PEND;
   assign irq = |(sticky & mask);

   // plain control/config registers; sticky bits set on events with set winning over W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl      <= '0;
         mask      <= '0;
         sticky    <= '0;
         ibase     <= RST_IBASE;
         obase     <= RST_OBASE;
         isize     <= RST_SIZE;
         osize     <= RST_SIZE;
         frame_adj <= '0;
      end else begin
         if (we && off == OFF_CTRL) ctrl <= din[3:0];
         if (we && off == OFF_MASK) mask <= din[3:0];
         if (we && off == OFF_IBASE) ibase <= din;
         if (we && off == OFF_ISIZE) isize <= din[23:6];
         if (we && off == OFF_OBASE) obase <= din;
         if (we && off == OFF_OSIZE) osize <= din[23:6];
         if (wr_adj) frame_adj <= din[23:0];
         sticky <= (sticky & ~sk_clr) | {commit_done, adj_ovr, oerr, ierr};
      end
   end

   // adjust FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) adj_st <= ADJ_IDLE;
      else adj_st <= adj_nx;
   end

   // adjust FSM next state; a rewrite while pending without a same-cycle ack flags an overrun
   always_comb begin
      adj_nx  = wr_adj ? ADJ_PEND : (adj_ack ? ADJ_IDLE : adj_st);
      adj_ovr = wr_adj && adj_st == ADJ_PEND && !adj_ack;
   end

`ifdef AXI2S_MREG_SHADOW_EN
   logic [23:0] s_len, s_ts, s_te, s_rs, s_re;
   logic        commit;
   assign commit = frame_strobe && (commit_pend || wr_len || wr_ts || wr_te || wr_rs || wr_re);
   assign commit_done = commit;

   // shadow timing registers and the pending-commit flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_len       <= RST_FRAME_LEN;
         s_ts        <= '0;
         s_te        <= RST_END;
         s_rs        <= '0;
         s_re        <= RST_END;
         commit_pend <= 1'b0;
      end else begin
         if (wr_len) s_len <= din[23:0];
         if (wr_ts) s_ts <= din[23:0];
         if (wr_te) s_te <= din[23:0];
         if (wr_rs) s_rs <= din[23:0];
         if (wr_re) s_re <= din[23:0];
         commit_pend <= commit ? 1'b0 : (commit_pend || wr_len || wr_ts || wr_te || wr_rs || wr_re);
      end
   end

   // active timing copies all shadows at once; a same-cycle write commits its new value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_len <= RST_FRAME_LEN;
         tstart    <= '0;
         tend      <= RST_END;
         rstart    <= '0;
         rend      <= RST_END;
      end else if (commit) begin
         frame_len <= wr_len ? din[23:0] : s_len;
         tstart    <= wr_ts ? din[23:0] : s_ts;
         tend      <= wr_te ? din[23:0] : s_te;
         rstart    <= wr_rs ? din[23:0] : s_rs;
         rend      <= wr_re ? din[23:0] : s_re;
      end
   end
`else
   logic unused_strobe;
   assign unused_strobe = frame_strobe;
   assign commit_pend = 1'b0;
   assign commit_done = 1'b0;

   // active timing written directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_len <= RST_FRAME_LEN;
         tstart    <= '0;
         tend      <= RST_END;
         rstart    <= '0;
         rend      <= RST_END;
      end else begin
         if (wr_len) frame_len <= din[23:0];
         if (wr_ts) tstart <= din[23:0];
         if (wr_te) tend <= din[23:0];
         if (wr_rs) rstart <= din[23:0];
         if (wr_re) rend <= din[23:0];
      end
   end
`endif

   // read data select; unmapped offsets read 0
   always_comb begin
      rdata = '0;
      case (off)
         OFF_STATE: begin
            rdata[ST_IEN]    = ien;
            rdata[ST_OEN]    = oen;
            rdata[ST_TDD]    = tddmode;
            rdata[ST_ADJ]    = adj_pending;
            rdata[ST_COMMIT] = commit_pend;
         end
         OFF_STICKY:    rdata[3:0] = sticky;
         OFF_MASK:      rdata[3:0] = mask;
         OFF_IACNT:     rdata[23:6] = iacnt;
         OFF_IBCNT:     rdata = ibcnt;
         OFF_OACNT:     rdata[23:6] = oacnt;
         OFF_OBCNT:     rdata = obcnt;
         OFF_FRAME_LEN: rdata[23:0] = frame_len;
         OFF_FRAME_ADJ: rdata[23:0] = frame_adj;
         OFF_TSTART:    rdata[23:0] = tstart;
         OFF_TEND:      rdata[23:0] = tend;
         OFF_RSTART:    rdata[23:0] = rstart;
         OFF_REND:      rdata[23:0] = rend;
         default:       rdata = '0;
      endcase
   end
endmodule

// File: rtl/axi2s_mreg.sv
// axi2s_mreg: multi-channel register block; decodes the window, fans out to channels, registers read data
// Build option: AXI2S_MREG_SHADOW_EN enables shadowed timing registers committed on frame_strobe.
module axi2s_mreg
   import axi2s_mreg_pkg::*;
#(
   parameter int          NCH  = 1,
   parameter logic [17:0] BASE = 18'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              wen,
   input  logic [17:0]       addr,
   input  logic [31:0]       din,
   output logic [31:0]       dout,
   output logic [NCH-1:0]    ien,
   output logic [NCH-1:0]    oen,
   output logic [NCH-1:0]    tddmode,
   output logic [NCH-1:0]    test,
   output logic [NCH*32-1:0] ibase,
   output logic [NCH*32-1:0] obase,
   output logic [NCH*18-1:0] isize,
   output logic [NCH*18-1:0] osize,
   output logic [NCH*24-1:0] frame_len,
   output logic [NCH*24-1:0] tstart,
   output logic [NCH*24-1:0] tend,
   output logic [NCH*24-1:0] rstart,
   output logic [NCH*24-1:0] rend,
   output logic [NCH*24-1:0] frame_adj,
   output logic [NCH-1:0]    adj_pending,
   input  logic [NCH-1:0]    adj_ack,
   input  logic [NCH-1:0]    frame_strobe,
   input  logic [NCH*18-1:0] iacnt,
   input  logic [NCH*18-1:0] oacnt,
   input  logic [NCH*32-1:0] ibcnt,
   input  logic [NCH*32-1:0] obcnt,
   input  logic [NCH-1:0]    ierr,
   input  logic [NCH-1:0]    oerr,
   output logic [NCH-1:0]    irq
);
   logic        hit;
   logic [1:0]  ch;
   logic [31:0] rd [NCH];
   logic [31:0] rsel;

   assign hit = en && addr[17:8] == BASE[17:8];
   assign ch  = addr[7:6];

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      axi2s_mreg_chan u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .we           (hit && wen && ch == 2'(c)),
         .off          (addr[5:0]),
         .din          (din),
         .rdata        (rd[c]),
         .ien          (ien[c]),
         .oen          (oen[c]),
         .tddmode      (tddmode[c]),
         .test         (test[c]),
         .ibase        (ibase[c*32 +: 32]),
         .obase        (obase[c*32 +: 32]),
         .isize        (isize[c*18 +: 18]),
         .osize        (osize[c*18 +: 18]),
         .frame_len    (frame_len[c*24 +: 24]),
         .tstart       (tstart[c*24 +: 24]),
         .tend         (tend[c*24 +: 24]),
         .rstart       (rstart[c*24 +: 24]),
         .rend         (rend[c*24 +: 24]),
         .frame_adj    (frame_adj[c*24 +: 24]),
         .adj_pending  (adj_pending[c]),
         .adj_ack      (adj_ack[c]),
         .frame_strobe (frame_strobe[c]),
         .iacnt        (iacnt[c*18 +: 18]),
         .oacnt        (oacnt[c*18 +: 18]),
         .ibcnt        (ibcnt[c*32 +: 32]),
         .obcnt        (obcnt[c*32 +: 32]),
         .ierr         (ierr[c]),
         .oerr         (oerr[c]),
         .irq          (irq[c])
      );
   end

   // channel read select; channels beyond NCH read 0
   always_comb begin
      rsel = '0;
      for (int c = 0; c < NCH; c++) rsel = (ch == 2'(c)) ? rd[c] : rsel;
   end

   // registered read data, zero when no read is in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout <= '0;
      else dout <= (hit && !wen) ? rsel : 32'h0;
   end
endmodule

// File: tb/tb_axi2s_mreg.sv
// tb_axi2s_mreg: directed self-checking bench for axi2s_mreg (NCH=4)
module tb_axi2s_mreg;
   localparam int          NCH  = 4;
   localparam logic [17:0] BASE = 18'h2A500;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              en = 1'b0, wen = 1'b0;
   logic [17:0]       addr = '0;
   logic [31:0]       din = '0;
   logic [31:0]       dout;
   logic [NCH-1:0]    ien, oen, tddmode, test, adj_pending, irq;
   logic [NCH-1:0]    adj_ack = '0, frame_strobe = '0, ierr = '0, oerr = '0;
   logic [NCH*32-1:0] ibase, obase;
   logic [NCH*18-1:0] isize, osize;
   logic [NCH*24-1:0] frame_len, tstart, tend, rstart, rend, frame_adj;
   logic [NCH*18-1:0] iacnt = '0, oacnt = '0;
   logic [NCH*32-1:0] ibcnt = '0, obcnt = '0;
   int checks = 0, errors = 0;
   logic [31:0] r;

   axi2s_mreg #(.NCH(NCH), .BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wen(wen), .addr(addr), .din(din), .dout(dout),
      .ien(ien), .oen(oen), .tddmode(tddmode), .test(test),
      .ibase(ibase), .obase(obase), .isize(isize), .osize(osize),
      .frame_len(frame_len), .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend),
      .frame_adj(frame_adj), .adj_pending(adj_pending), .adj_ack(adj_ack),
      .frame_strobe(frame_strobe), .iacnt(iacnt), .oacnt(oacnt), .ibcnt(ibcnt), .obcnt(obcnt),
      .ierr(ierr), .oerr(oerr), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] mk(input logic [1:0] c, input logic [5:0] o);
      return {BASE[17:8], c, o};
   endfunction

   task automatic wr(input logic [1:0] c, input logic [5:0] o, input logic [31:0] d);
      @(negedge clk);
      en = 1'b1; wen = 1'b1; addr = mk(c, o); din = d;
      @(negedge clk);
      en = 1'b0; wen = 1'b0;
   endtask

   task automatic rd_at(input logic [17:0] a, output logic [31:0] d);
      @(negedge clk);
      en = 1'b1; wen = 1'b0; addr = a;
      @(negedge clk);
      en = 1'b0;
      d = dout;
   endtask

   task automatic rd(input logic [1:0] c, input logic [5:0] o, output logic [31:0] d);
      rd_at(mk(c, o), d);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_pend", 32'(adj_pending), 32'h0);
      check("rst_dout", dout, 32'h0);
      check("rst_ibase2", ibase[64 +: 32], 32'hFFFC_0000);
      check("rst_obase3", obase[96 +: 32], 32'hFFFD_0000);
      check("rst_isize0", 32'(isize[17:0]), 32'h400);
      check("rst_flen0", 32'(frame_len[23:0]), 32'd1920);
      check("rst_tend0", 32'(tend[23:0]), 32'd1919);
      check("rst_tstart0", 32'(tstart[23:0]), 32'h0);
      rst_n = 1'b1;
      rd(2'd0, 6'h20, r); check("rd_flen0", r, 32'd1920);
      rd(2'd0, 6'h34, r); check("rd_tend0", r, 32'd1919);
      @(negedge clk); check("dout_idle", dout, 32'h0);
      // control and config writes
      wr(2'd1, 6'h00, 32'hF);
      check("ien", 32'(ien), 32'h2);
      check("test", 32'(test), 32'h2);
      rd(2'd1, 6'h00, r); check("state1", r, 32'h7);
      wr(2'd2, 6'h10, 32'hDEADBEEF); check("ibase2", ibase[64 +: 32], 32'hDEADBEEF);
      wr(2'd0, 6'h14, 32'hFFABCDC0); check("isize0", 32'(isize[17:0]), 32'h2AF37);
      // counter reads
      iacnt[17:0] = 18'h3FFFF; ibcnt[96 +: 32] = 32'h12345678;
      rd(2'd0, 6'h10, r); check("iacnt0", r, 32'h00FFFFC0);
      rd(2'd3, 6'h14, r); check("ibcnt3", r, 32'h12345678);
      // frame adjust handshake
      wr(2'd2, 6'h24, 32'h123);
      check("adj_pend", 32'(adj_pending), 32'h4);
      check("adj_val", 32'(frame_adj[48 +: 24]), 32'h123);
      rd(2'd2, 6'h00, r); check("state2", r, 32'h8);
      @(negedge clk); adj_ack = 4'b0100;
      @(negedge clk); adj_ack = '0;
      check("adj_ack", 32'(adj_pending), 32'h0);
      wr(2'd2, 6'h24, 32'h55);
      wr(2'd2, 6'h24, 32'h66);
      check("adj_ovr_val", 32'(frame_adj[48 +: 24]), 32'h66);
      rd(2'd2, 6'h04, r); check("adj_ovr", r, 32'h4);
      wr(2'd2, 6'h04, 32'h4);
      @(negedge clk);
      en = 1'b1; wen = 1'b1; addr = mk(2'd2, 6'h24); din = 32'h77; adj_ack = 4'b0100;
      @(negedge clk);
      en = 1'b0; wen = 1'b0; adj_ack = '0;
      check("adj_wack_pend", 32'(adj_pending), 32'h4);
      check("adj_wack_val", 32'(frame_adj[48 +: 24]), 32'h77);
      rd(2'd2, 6'h04, r); check("adj_wack_noovr", r, 32'h0);
      // timing writes and frame_strobe
      wr(2'd1, 6'h34, 32'd999);
`ifdef AXI2S_MREG_SHADOW_EN
      check("sh_tend_hold", 32'(tend[24 +: 24]), 32'd1919);
      rd(2'd1, 6'h00, r); check("sh_state", r, 32'h17);
`else
      check("tend_direct", 32'(tend[24 +: 24]), 32'd999);
      rd(2'd1, 6'h00, r); check("state_nocommit", r, 32'h7);
`endif
      @(negedge clk); frame_strobe = 4'b0010;
      @(negedge clk); frame_strobe = '0;
      check("tend_commit", 32'(tend[24 +: 24]), 32'd999);
      rd(2'd1, 6'h04, r);
`ifdef AXI2S_MREG_SHADOW_EN
      check("commit_done", r, 32'h8);
`else
      check("no_commit_done", r, 32'h0);
`endif
      // interrupt and W1C with same-cycle set
      wr(2'd0, 6'h08, 32'h1);
      @(negedge clk); ierr = 4'b0001;
      @(negedge clk); ierr = '0;
      check("irq_set", 32'(irq), 32'h1);
      @(negedge clk);
      en = 1'b1; wen = 1'b1; addr = mk(2'd0, 6'h04); din = 32'h1; ierr = 4'b0001;
      @(negedge clk);
      en = 1'b0; wen = 1'b0; ierr = '0;
      check("irq_setwins", 32'(irq), 32'h1);
      rd(2'd0, 6'h04, r); check("sticky_setwins", r, 32'h1);
      wr(2'd0, 6'h04, 32'h1); check("irq_clr", 32'(irq), 32'h0);
      @(negedge clk); oerr = 4'b0001;
      @(negedge clk); oerr = '0;
      check("irq_masked", 32'(irq), 32'h0);
      rd(2'd0, 6'h04, r); check("sticky_oerr", r, 32'h2);
      // decode misses
      rd_at({BASE[17:8] ^ 10'h1, 2'd0, 6'h20}, r); check("rd_wrong_base", r, 32'h0);
      @(negedge clk);
      en = 1'b1; wen = 1'b1; addr = {BASE[17:8] ^ 10'h1, 2'd0, 6'h30}; din = 32'h5;
      @(negedge clk);
      en = 1'b0; wen = 1'b0;
      check("wr_wrong_base", 32'(tstart[23:0]), 32'h0);
      rd(2'd0, 6'h0C, r); check("rd_unmapped", r, 32'h0);
      // async reset while pending
      wr(2'd0, 6'h24, 32'h9);
      check("pend_before_rst", 32'(adj_pending), 32'h5);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("rst_async_pend", 32'(adj_pending), 32'h0);
      check("rst_async_ibase", ibase[64 +: 32], 32'hFFFC_0000);
      check("rst_async_tend", 32'(tend[24 +: 24]), 32'd1919);
      @(negedge clk); rst_n = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
